// File: rtl/controller_gcd_if.sv
// Handshake and strobe bundle between the GCD controller, its datapath and the host.
// The controller takes the slave view; whoever drives start and the comparator flags takes master.
interface controller_gcd_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             x_neq_y;
  logic             x_lt_y;
  logic             x_sel;
  logic             y_sel;
  logic             x_ld;
  logic             y_ld;
  logic             d_ld;
  logic             busy;
  logic             done;
  logic             fault;
  logic [CNT_W-1:0] iter_count;

  modport slave (
    input  start, x_neq_y, x_lt_y,
    output x_sel, y_sel, x_ld, y_ld, d_ld, busy, done, fault, iter_count
  );

  modport master (
    output start, x_neq_y, x_lt_y,
    input  x_sel, y_sel, x_ld, y_ld, d_ld, busy, done, fault, iter_count
  );
endinterface

// File: rtl/controller_gcd.sv
// Moore controller for the 4-bit subtractive GCD datapath: sequences loads, counts
// subtractions, and parks in FAULT when the subtraction budget runs out with x != y.
module controller_gcd #(
  parameter int MAX_ITER = 15,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  controller_gcd_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_SUBX  = 3'd3,
    ST_SUBY  = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAULT = 3'd7
  } state_e;

  typedef struct packed {
    logic x_sel;
    logic y_sel;
    logic x_ld;
    logic y_ld;
    logic d_ld;
    logic busy;
    logic done;
    logic fault;
  } strobes_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  // Strobes are decoded from the state being entered and then registered, so every
  // output is a flop: no input-to-output path and reset clears them instantly.
  function automatic strobes_t decode_strobes(input state_e st);
    strobes_t s;
    s = '0;
    case (st)
      ST_IDLE:  s = '0;
      ST_LOAD:  begin s.x_ld = 1'b1; s.y_ld = 1'b1; s.busy = 1'b1; end
      ST_CHECK: s.busy = 1'b1;
      ST_SUBX:  begin s.x_sel = 1'b1; s.x_ld = 1'b1; s.busy = 1'b1; end
      ST_SUBY:  begin s.y_sel = 1'b1; s.y_ld = 1'b1; s.busy = 1'b1; end
      ST_WRITE: begin s.d_ld = 1'b1; s.busy = 1'b1; end
      ST_DONE:  s.done = 1'b1;
      ST_FAULT: s.fault = 1'b1;
      default:  s = '0;
    endcase
    return s;
  endfunction

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  strobes_t         strb_d, strb_q;

  // Next-state selection, iteration counter update and strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strb_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_LOAD;
        else           state_d = ST_IDLE;
      end
      ST_LOAD:  state_d = ST_CHECK;
      ST_CHECK: begin
        if (!bus.x_neq_y)          state_d = ST_WRITE;
        else if (cnt_q == MAX_CNT) state_d = ST_FAULT;
        else if (bus.x_lt_y)       state_d = ST_SUBY;
        else                       state_d = ST_SUBX;
      end
      ST_SUBX:  state_d = ST_CHECK;
      ST_SUBY:  state_d = ST_CHECK;
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: begin
        if (bus.start) state_d = ST_LOAD;
        else           state_d = ST_FAULT;
      end
      default:  state_d = ST_IDLE;
    endcase

    // The FAULT check above keeps the count from ever passing MAX_ITER.
    if (state_d == ST_LOAD) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((state_d == ST_SUBX) || (state_d == ST_SUBY)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    strb_d = decode_strobes(state_d);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      strb_q  <= strb_d;
    end
  end

  assign bus.x_sel      = strb_q.x_sel;
  assign bus.y_sel      = strb_q.y_sel;
  assign bus.x_ld       = strb_q.x_ld;
  assign bus.y_ld       = strb_q.y_ld;
  assign bus.d_ld       = strb_q.d_ld;
  assign bus.busy       = strb_q.busy;
  assign bus.done       = strb_q.done;
  assign bus.fault      = strb_q.fault;
  assign bus.iter_count = cnt_q;

endmodule

// File: tb/tb_controller_gcd.sv
// Bench for controller_gcd: a behavioural falling-edge datapath closes the loop, and an
// arithmetic GCD model predicts result, subtraction count and handshake timing per run.
module tb_controller_gcd;

  localparam int MAX_ITER = 15;
  localparam int CNT_W    = 4;

  logic clk;
  logic reset;
  logic [3:0] x_in, y_in;
  logic [3:0] x_reg, y_reg, d_reg;

  int n_cmp;
  int n_err;

  controller_gcd_if #(.CNT_W(CNT_W)) bus ();

  controller_gcd #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: registers load on the falling edge from the controller's strobes.
  always @(negedge clk) begin
    if (bus.x_ld) x_reg <= bus.x_sel ? (x_reg - y_reg) : x_in;
    if (bus.y_ld) y_reg <= bus.y_sel ? (y_reg - x_reg) : y_in;
    if (bus.d_ld) d_reg <= x_reg;
  end

  assign bus.x_neq_y = (x_reg != y_reg);
  assign bus.x_lt_y  = (x_reg < y_reg);

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Subtractive Euclid with a step budget; flt means the budget ran out with a != b.
  function automatic void ref_gcd(input int xa, input int ya,
                                  output int n, output bit flt, output int d);
    int a;
    int b;
    a = xa; b = ya; n = 0; flt = 1'b0;
    while (a != b) begin
      if (n == MAX_ITER) begin
        flt = 1'b1;
        break;
      end
      if (a < b) b = b - a;
      else       a = a - b;
      n++;
    end
    d = a;
  endfunction

  // One run from IDLE/FAULT; sample k is taken 1 time unit after rising edge E_k.
  task automatic run_gcd(input int xa, input int ya, input bit toggle, input string tag);
    int  n, d, end_k, done_cyc, fault_cyc, ndone;
    bit  flt, busy_ok, exp_busy;
    ref_gcd(xa, ya, n, flt, d);
    end_k     = flt ? (3 + 2 * MAX_ITER) : (4 + 2 * n);
    done_cyc  = -1;
    fault_cyc = -1;
    ndone     = 0;
    busy_ok   = 1'b1;
    x_in      = 4'(xa);
    y_in      = 4'(ya);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k <= end_k; k++) begin
      if (bus.done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (bus.fault && fault_cyc < 0) fault_cyc = k;
      exp_busy = flt ? (k <= 1 + 2 * MAX_ITER) : (k <= 2 + 2 * n);
      if (bus.busy !== exp_busy) busy_ok = 1'b0;
      if (toggle && k < 2 + 2 * n) bus.start = ~bus.start;
      else                         bus.start = 1'b0;
      if (k < end_k) begin
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    check_val({tag, ".busy"},  int'(busy_ok), 1);
    check_val({tag, ".ndone"}, ndone, flt ? 0 : 1);
    check_val({tag, ".done_cyc"}, done_cyc, flt ? -1 : (3 + 2 * n));
    check_val({tag, ".fault_cyc"}, fault_cyc, flt ? (2 + 2 * MAX_ITER) : -1);
    check_val({tag, ".iter"}, int'(bus.iter_count), n);
    if (!flt) check_val({tag, ".d_out"}, int'(d_reg), d);
    else      check_val({tag, ".fault_held"}, int'(bus.fault), 1);
  endtask

  // start held high: two back-to-back gcd(9,6) runs separated by one IDLE cycle.
  task automatic run_back_to_back();
    int d1, d2;
    bit b8, b9;
    d1 = -1; d2 = -1; b8 = 1'b1; b9 = 1'b0;
    x_in = 4'd9; y_in = 4'd6;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= 17; k++) begin
      if (bus.done) begin
        if (d1 < 0) d1 = k;
        else        d2 = k;
      end
      if (k == 8) b8 = bus.busy;
      if (k == 9) b9 = bus.busy;
      if (k >= 10) bus.start = 1'b0;
      if (k < 17) begin
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    check_val("b2b.done1", d1, 7);
    check_val("b2b.done2", d2, 16);
    check_val("b2b.idle_gap", int'(b8), 0);
    check_val("b2b.relaunch", int'(b9), 1);
    check_val("b2b.d_out", int'(d_reg), 3);
  endtask

  function automatic int outs_word();
    return int'({bus.x_sel, bus.y_sel, bus.x_ld, bus.y_ld, bus.d_ld,
                 bus.busy, bus.done, bus.fault, bus.iter_count});
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    x_in = 4'd0; y_in = 4'd0;
    x_reg = 4'd0; y_reg = 4'd0; d_reg = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset.outs", outs_word(), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("idle.outs", outs_word(), 0);

    run_gcd(12, 8, 1'b0, "g12_8");
    run_gcd(7, 7, 1'b0, "g7_7");
    run_gcd(0, 0, 1'b0, "g0_0");
    run_gcd(15, 1, 1'b0, "g15_1");
    run_gcd(0, 5, 1'b0, "g0_5");
    run_gcd(6, 4, 1'b0, "g6_4");
    run_gcd(9, 6, 1'b1, "g9_6_tgl");
    repeat (2) @(posedge clk);
    #1;
    run_back_to_back();
    repeat (2) @(posedge clk);
    #1;

    // Reset lands between edges while SUBX is driving x_ld; no load may follow.
    x_in = 4'd15; y_in = 4'd1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_mid.in_subx", int'(bus.x_ld & bus.x_sel), 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_mid.outs", outs_word(), 0);
    @(negedge clk); #1;
    check_val("rst_mid.no_load", int'(x_reg), 15);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_gcd(10, 4, 1'b0, "g10_4");

    for (int i = 0; i < 20; i++) begin
      run_gcd(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
